// File: rtl/proc_feeder_pkg.sv
// Shared constants for the instruction feeder: opcode encodings, HALT mask, FSM states.
package proc_feeder_pkg;

  localparam int unsigned DataW = 9;

  // Instruction word: [8:6] opcode, [5:3] X, [2:0] Y.
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Any opcode with this bit set is a HALT and is never issued.
  localparam logic [2:0] OP_HALT_MASK = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StImm,
    StWait,
    StHalted,
    StError
  } state_e;

  function automatic logic is_halt(input logic [2:0] op);
    return (op & OP_HALT_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/proc_feeder_prog_mem.sv
// 1R1W program memory with a registered read; contents survive reset.
module prog_mem #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Synchronous write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/proc_feeder.sv
// Steps a PC through program memory, issuing each instruction (and mvi immediate) to the
// processor with a one-cycle Run strobe, then waits for Done or times out.
module proc_feeder
  import proc_feeder_pkg::*;
#(
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ld_en_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [DataW-1:0] ld_data_i,
  input  logic             done_i,
  output logic [DataW-1:0] din_o,
  output logic             run_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [AW-1:0]    pc_o
);

  // Wide enough to hold TIMEOUT with headroom.
  localparam int unsigned CW = $clog2(TIMEOUT + 2);

  state_e           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mvi_q, mvi_d;
  logic [AW-1:0]    raddr;
  logic [DataW-1:0] rdata;
  logic [2:0]       opcode;
  logic [AW-1:0]    pc_inc1, pc_inc2;

  assign opcode  = rdata[8:6];
  assign pc_inc1 = pc_q + AW'(1);
  assign pc_inc2 = pc_q + AW'(2);

  assign busy_o   = (state_q == StFetch) || (state_q == StIssue) ||
                    (state_q == StImm)   || (state_q == StWait);
  assign halted_o = (state_q == StHalted);
  assign err_o    = (state_q == StError);
  assign pc_o     = pc_q;

  prog_mem #(
    .AW (AW),
    .DW (DataW)
  ) u_prog_mem (
    .clk_i   (clk_i),
    .we_i    (ld_en_i && !busy_o),
    .waddr_i (ld_addr_i),
    .wdata_i (ld_data_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Next-state, PC/counter update, memory read address and processor-facing outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mvi_d   = mvi_q;
    raddr   = pc_q;
    run_o   = 1'b0;
    din_o   = '0;
    unique case (state_q)
      StIdle, StHalted, StError: begin
        if (start_i) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: state_d = StIssue;
      StIssue: begin
        // Prefetch PC+1 so the mvi immediate is ready in IMM.
        raddr = pc_inc1;
        cnt_d = '0;
        mvi_d = (opcode == OP_MVI);
        if (!is_halt(opcode)) begin
          din_o = rdata;
          run_o = 1'b1;
        end
        case (opcode)
          OP_MVI:                 state_d = StImm;
          OP_MV, OP_ADD, OP_SUB:  state_d = StWait;
          default:                state_d = StHalted;
        endcase
      end
      StImm: begin
        din_o = rdata;
        if (done_i) begin
          pc_d    = pc_inc2;
          state_d = StFetch;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (done_i) begin
          pc_d    = mvi_q ? pc_inc2 : pc_inc1;
          state_d = StFetch;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      mvi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mvi_q   <= mvi_d;
    end
  end

endmodule

// File: tb/tb_proc_feeder.sv
// Scoreboard bench for proc_feeder: stimulus pushes expected issues, a monitor pops them on Run.
module tb_proc_feeder;

  localparam int unsigned AW      = 5;
  localparam int unsigned TIMEOUT = 15;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          ld_en_i = 1'b0;
  logic [AW-1:0] ld_addr_i = '0;
  logic [8:0]    ld_data_i = '0;
  logic          done_i = 1'b0;
  logic [8:0]    din_o;
  logic          run_o;
  logic          busy_o;
  logic          halted_o;
  logic          err_o;
  logic [AW-1:0] pc_o;

  proc_feeder #(
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ld_en_i   (ld_en_i),
    .ld_addr_i (ld_addr_i),
    .ld_data_i (ld_data_i),
    .done_i    (done_i),
    .din_o     (din_o),
    .run_o     (run_o),
    .busy_o    (busy_o),
    .halted_o  (halted_o),
    .err_o     (err_o),
    .pc_o      (pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [8:0] din;
    logic       has_imm;
    logic [8:0] imm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_count = 0;
  int   last_run_cyc = -1;
  int   prev_run_cyc = -1;
  int   done_delay = -1;  // cycles of extra Done latency; negative means never answer
  int   runs_before;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [8:0] din, input logic has_imm, input logic [8:0] imm);
    exp_t it;
    it.din = din;
    it.has_imm = has_imm;
    it.imm = imm;
    sb.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [8:0] data);
    ld_en_i = 1'b1;
    ld_addr_i = addr;
    ld_data_i = data;
    @(negedge clk_i);
    ld_en_i = 1'b0;
  endtask

  // Leaves the caller just after the edge that sampled Start.
  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted_o) break;
      @(negedge clk_i);
    end
    chk(name, 32'(halted_o), 32'd1);
  endtask

  // Processor model: raise Done for one cycle, done_delay cycles after the cycle following Run.
  task automatic responder();
    forever begin
      @(negedge clk_i);
      if (run_o && done_delay >= 0) begin
        @(negedge clk_i);
        repeat (done_delay) @(negedge clk_i);
        done_i = 1'b1;
        @(negedge clk_i);
        done_i = 1'b0;
      end
    end
  endtask

  // Pops the scoreboard on each Run and checks the issued word and any immediate that follows.
  task automatic monitor();
    exp_t       it;
    logic       prev_run;
    logic       imm_pend;
    logic [8:0] imm_exp;
    prev_run = 1'b0;
    imm_pend = 1'b0;
    imm_exp  = '0;
    forever begin
      @(negedge clk_i);
      if (imm_pend) begin
        chk("imm_din", 32'(din_o), 32'(imm_exp));
        chk("imm_run_low", 32'(run_o), 32'd0);
        imm_pend = 1'b0;
      end
      if (run_o) begin
        chk("run_not_back_to_back", 32'(prev_run), 32'd0);
        prev_run_cyc = last_run_cyc;
        last_run_cyc = cyc;
        run_count++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: got Run with DIN=0x%0h, expected no Run", din_o);
        end else begin
          it = sb.pop_front();
          chk("run_din", 32'(din_o), 32'(it.din));
          if (it.has_imm) begin
            imm_pend = 1'b1;
            imm_exp  = it.imm;
          end
        end
      end
      prev_run = run_o;
    end
  endtask

  initial begin
    fork
      monitor();
      responder();
    join_none

    // Reset state
    tick(2);
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_run", 32'(run_o), 32'd0);
    chk("rst_din", 32'(din_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;

    // T1: mv R1,R2 then HALT; halted five edges after Start
    load(5'd0, 9'h00A);
    load(5'd1, 9'h100);
    done_delay = 0;
    expect_issue(9'h00A, 1'b0, 9'h000);
    pulse_start();
    tick(4);
    chk("t1_halt_issue_no_run", 32'(run_o), 32'd0);
    chk("t1_not_yet_halted", 32'(halted_o), 32'd0);
    tick(1);
    chk("t1_halted", 32'(halted_o), 32'd1);
    chk("t1_pc", 32'(pc_o), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd0);

    // T2: mvi R3 with immediate 0x1A5, Done in IMM; PC jumps 0 -> 2
    load(5'd0, 9'h058);
    load(5'd1, 9'h1A5);
    load(5'd2, 9'h100);
    expect_issue(9'h058, 1'b1, 9'h1A5);
    pulse_start();
    tick(3);
    chk("t2_pc_after_mvi", 32'(pc_o), 32'd2);
    tick(2);
    chk("t2_halted", 32'(halted_o), 32'd1);
    chk("t2_pc", 32'(pc_o), 32'd2);

    // T3: add, sub with Done two cycles late; Run cycles differ by 5 (6 cycles inclusive)
    load(5'd0, 9'h081);
    load(5'd1, 9'h0D3);
    load(5'd2, 9'h100);
    done_delay = 2;
    expect_issue(9'h081, 1'b0, 9'h000);
    expect_issue(9'h0D3, 1'b0, 9'h000);
    pulse_start();
    tick(11);
    chk("t3_not_yet_halted", 32'(halted_o), 32'd0);
    tick(1);
    chk("t3_halted", 32'(halted_o), 32'd1);
    chk("t3_pc", 32'(pc_o), 32'd2);
    chk("t3_err", 32'(err_o), 32'd0);
    chk("t3_run_spacing", 32'(last_run_cyc - prev_run_cyc), 32'd5);

    // T4: no Done -> ERROR TIMEOUT+1 cycles after entering WAIT, then restart
    load(5'd0, 9'h00A);
    load(5'd1, 9'h100);
    done_delay = -1;
    expect_issue(9'h00A, 1'b0, 9'h000);
    pulse_start();
    tick(17);
    chk("t4_err_not_yet", 32'(err_o), 32'd0);
    chk("t4_busy_waiting", 32'(busy_o), 32'd1);
    tick(1);
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_err_pc", 32'(pc_o), 32'd0);
    chk("t4_err_busy", 32'(busy_o), 32'd0);
    tick(3);
    chk("t4_err_run", 32'(run_o), 32'd0);
    chk("t4_err_held", 32'(err_o), 32'd1);
    done_delay = 0;
    expect_issue(9'h00A, 1'b0, 9'h000);
    pulse_start();
    chk("t4_err_cleared", 32'(err_o), 32'd0);
    chk("t4_restart_pc", 32'(pc_o), 32'd0);
    wait_halted("t4_rerun_halted", 20);
    chk("t4_rerun_pc", 32'(pc_o), 32'd1);

    // T5: LdEn and Start while Busy are ignored
    load(5'd0, 9'h081);
    load(5'd1, 9'h100);
    done_delay = 4;
    expect_issue(9'h081, 1'b0, 9'h000);
    pulse_start();
    ld_en_i = 1'b1;
    ld_addr_i = 5'd0;
    ld_data_i = 9'h1FF;
    start_i = 1'b1;
    tick(3);
    ld_en_i = 1'b0;
    start_i = 1'b0;
    chk("t5_pc_held", 32'(pc_o), 32'd0);
    chk("t5_still_busy", 32'(busy_o), 32'd1);
    wait_halted("t5_halted", 20);
    chk("t5_pc", 32'(pc_o), 32'd1);
    done_delay = 0;
    runs_before = run_count;
    expect_issue(9'h081, 1'b0, 9'h000);
    pulse_start();
    wait_halted("t5_rerun_halted", 20);
    chk("t5_rerun_pc", 32'(pc_o), 32'd1);
    chk("t5_rerun_runs", 32'(run_count - runs_before), 32'd1);

    // T6: Reset in WAIT returns to IDLE; memory survives
    done_delay = -1;
    expect_issue(9'h081, 1'b0, 9'h000);
    pulse_start();
    tick(3);
    chk("t6_in_wait", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_run", 32'(run_o), 32'd0);
    chk("t6_pc", 32'(pc_o), 32'd0);
    chk("t6_din", 32'(din_o), 32'd0);
    chk("t6_halted", 32'(halted_o), 32'd0);
    tick(20);
    chk("t6_idle_no_err", 32'(err_o), 32'd0);
    done_delay = 0;
    expect_issue(9'h081, 1'b0, 9'h000);
    pulse_start();
    wait_halted("t6_rerun_halted", 20);
    chk("t6_rerun_pc", 32'(pc_o), 32'd1);

    // T7: wrap-around; mvi at address 31 takes its immediate from address 0
    load(5'd0, 9'h058);
    load(5'd1, 9'h100);
    for (int a = 2; a < 31; a++) load(AW'(a), 9'h00A);
    load(5'd31, 9'h058);
    expect_issue(9'h058, 1'b1, 9'h100);
    for (int a = 2; a < 31; a++) expect_issue(9'h00A, 1'b0, 9'h000);
    expect_issue(9'h058, 1'b1, 9'h058);
    pulse_start();
    wait_halted("t7_halted", 200);
    chk("t7_pc", 32'(pc_o), 32'd1);
    tick(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
